mux_sel_serializer: RTL and testbench

//  Upstream sequencer for a 4:1 data-flow mux. Accepts a 4-bit parallel word, then steps the
//  2-bit select through 0..3 and drives it to the mux stage. Emits the selected bit as a

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/mux_sel_serializer_if.sv | 25 ++
 rtl/mux4_pick.sv | 22 ++
 rtl/mux_sel_serializer.sv | 126 ++++++++++++
 tb/tb_mux_sel_serializer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux select serializer: select/input widths,
// FSM state encoding, gap counter width and the parity helper.
package mux_scan_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_IN = 4;
    localparam int GAP_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        GAP    = 2'd3
    } state_e;

    function automatic logic even_parity(input logic [NUM_IN-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mux_sel_serializer_if.sv
// Load and serial-stream handshake bundle for mux_sel_serializer.
// The master drives words in and accepts bits; the slave is the serializer.
interface mux_sel_serializer_if;
    import mux_scan_pkg::*;

    logic              load_valid;
    logic              load_ready;
    logic [NUM_IN-1:0] din;
    logic [SEL_W-1:0]  sel;
    logic              ser_data;
    logic              ser_valid;
    logic              ser_ready;
    logic              ser_last;

    modport master (
        output load_valid, din, ser_ready,
        input  load_ready, sel, ser_data, ser_valid, ser_last
    );

    modport slave (
        input  load_valid, din, ser_ready,
        output load_ready, sel, ser_data, ser_valid, ser_last
    );

endinterface

// File: rtl/mux4_pick.sv
// Combinational 4:1 bit select: y = i[s].
module mux4_pick
    import mux_scan_pkg::*;
(
    input  logic [NUM_IN-1:0] i,
    input  logic [SEL_W-1:0]  s,
    output logic              y
);

    // Select one input bit by index.
    always_comb begin
        y = 1'b0;
        case (s)
            2'd0:    y = i[0];
            2'd1:    y = i[1];
            2'd2:    y = i[2];
            2'd3:    y = i[3];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux_sel_serializer.sv
// Parallel-to-serial sequencer stepping a 4:1 mux select LSB first.
// Optional even-parity trailer beat when MUX_SEL_SERIALIZER_PARITY_EN is defined.
module mux_sel_serializer
    import mux_scan_pkg::*;
#(
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_sel_serializer_if.slave  bus
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_IN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (IDLE_GAP == 32'd0) ? '0 : GAP_W'(IDLE_GAP - 32'd1);
    localparam state_e           POST_FRAME = (IDLE_GAP == 32'd0) ? IDLE : GAP;

    state_e            state_r;
    state_e            state_s;
    logic [NUM_IN-1:0] word_r;
    logic [NUM_IN-1:0] word_s;
    logic [SEL_W-1:0]  sel_r;
    logic [SEL_W-1:0]  sel_s;
    logic [GAP_W-1:0]  gap_cnt_r;
    logic [GAP_W-1:0]  gap_cnt_s;
    logic              load_ready_r;
    logic              pick_s;
    logic              ser_data_s;
    logic              ser_valid_s;
    logic              ser_last_s;

    mux4_pick u_pick (
        .i (word_r),
        .s (sel_r),
        .y (pick_s)
    );

    // Next-state, datapath updates and stream outputs.
    always_comb begin
        state_s     = state_r;
        word_s      = word_r;
        sel_s       = sel_r;
        gap_cnt_s   = gap_cnt_r;
        ser_data_s  = 1'b0;
        ser_valid_s = 1'b0;
        ser_last_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_ready_r && bus.load_valid) begin
                    word_s  = bus.din;
                    sel_s   = '0;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                ser_valid_s = 1'b1;
                ser_data_s  = pick_s;
`ifdef MUX_SEL_SERIALIZER_PARITY_EN
                ser_last_s  = 1'b0;
`else
                ser_last_s  = (sel_r == SEL_LAST);
`endif
                if (bus.ser_ready && (sel_r != SEL_LAST)) begin
                    sel_s = sel_r + 2'd1;
                end else if (bus.ser_ready) begin
`ifdef MUX_SEL_SERIALIZER_PARITY_EN
                    state_s   = PARITY;
`else
                    state_s   = POST_FRAME;
                    gap_cnt_s = '0;
`endif
                end else begin
                    sel_s = sel_r;
                end
            end
`ifdef MUX_SEL_SERIALIZER_PARITY_EN
            PARITY: begin
                ser_valid_s = 1'b1;
                ser_data_s  = even_parity(word_r);
                ser_last_s  = 1'b1;
                if (bus.ser_ready) begin
                    state_s   = POST_FRAME;
                    gap_cnt_s = '0;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_s = IDLE;
                end else begin
                    gap_cnt_s = gap_cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; load_ready is registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            word_r       <= '0;
            sel_r        <= '0;
            gap_cnt_r    <= '0;
            load_ready_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            word_r       <= word_s;
            sel_r        <= sel_s;
            gap_cnt_r    <= gap_cnt_s;
            load_ready_r <= (state_s == IDLE);
        end
    end

    assign bus.load_ready = load_ready_r;
    assign bus.sel        = sel_r;
    assign bus.ser_data   = ser_data_s;
    assign bus.ser_valid  = ser_valid_s;
    assign bus.ser_last   = ser_last_s;

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Scoreboard bench for mux_sel_serializer (IDLE_GAP=3), directed vectors;
// honours MUX_SEL_SERIALIZER_PARITY_EN for the trailer beat.
module tb_mux_sel_serializer;
    import mux_scan_pkg::*;

    localparam int unsigned GAP = 3;
`ifdef MUX_SEL_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] sel;
        logic       data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_cyc = 0;
    int   hs_cyc   = 0;
    beat_t exp_q[$];

    mux_sel_serializer_if bus ();

    mux_sel_serializer #(.IDLE_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every accepted beat; log handshake cycles.
    always @(negedge clk) begin
        beat_t b;
        if (!rst && bus.ser_valid && bus.ser_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got sel=%0d data=%0b with empty queue", bus.sel, bus.ser_data);
            end else begin
                b = exp_q.pop_front();
                chk("beat_sel",  32'(bus.sel),      32'(b.sel));
                chk("beat_data", 32'(bus.ser_data), 32'(b.data));
                chk("beat_last", 32'(bus.ser_last), 32'(b.last));
            end
            if (bus.ser_last) last_cyc = cyc;
        end
        if (!rst && bus.load_valid && bus.load_ready) hs_cyc = cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [3:0] w);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{sel: 2'(k), data: w[k], last: (k == 3) && !PAR});
        end
        if (PAR) exp_q.push_back('{sel: 2'd3, data: ^w, last: 1'b1});
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.load_ready && n < 100) begin
            step();
            n++;
        end
        chk("wait_ready", 32'(bus.load_ready), 32'd1);
    endtask

    task automatic send_word(input logic [3:0] w);
        wait_ready();
        push_word(w);
        bus.load_valid = 1'b1;
        bus.din        = w;
        step();
        bus.load_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!((exp_q.size() == 0) && bus.load_ready) && n < 200) begin
            step();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int a_hs;
        bus.load_valid = 1'b0;
        bus.din        = 4'd0;
        bus.ser_ready  = 1'b0;

        // 1: reset values, load_ready rises after release
        step();
        chk("rst_load_ready", 32'(bus.load_ready), 32'd0);
        chk("rst_ser_valid",  32'(bus.ser_valid),  32'd0);
        chk("rst_ser_data",   32'(bus.ser_data),   32'd0);
        chk("rst_ser_last",   32'(bus.ser_last),   32'd0);
        chk("rst_sel",        32'(bus.sel),        32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", 32'(bus.load_ready), 32'd1);

        // 2: basic frame
        bus.ser_ready = 1'b1;
        send_word(4'b1011);
        chk("first_valid", 32'(bus.ser_valid), 32'd1);
        wait_drain();

        // 3: stall at sel=1
        send_word(4'b0110);
        step();
        bus.ser_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_sel",   32'(bus.sel),       32'd1);
            chk("stall_data",  32'(bus.ser_data),  32'd1);
            chk("stall_valid", 32'(bus.ser_valid), 32'd1);
            chk("stall_last",  32'(bus.ser_last),  32'd0);
        end
        bus.ser_ready = 1'b1;
        wait_drain();

        // 4: back-to-back loads, gap of GAP cycles
        push_word(4'b1100);
        push_word(4'b0011);
        bus.load_valid = 1'b1;
        bus.din        = 4'b1100;
        step();
        a_hs    = hs_cyc;
        bus.din = 4'b0011;
        for (int i = 0; i < 60; i++) begin
            if (hs_cyc != a_hs) break;
            step();
        end
        bus.load_valid = 1'b0;
        chk("gap_len", 32'(hs_cyc - last_cyc), 32'(GAP + 1));
        wait_drain();

        // 5: reset mid-frame at sel=2
        exp_q.push_back('{sel: 2'd0, data: 1'b1, last: 1'b0});
        exp_q.push_back('{sel: 2'd1, data: 1'b0, last: 1'b0});
        wait_ready();
        bus.load_valid = 1'b1;
        bus.din        = 4'b0101;
        step();
        bus.load_valid = 1'b0;
        step();
        step();
        chk("abort_sel_before", 32'(bus.sel), 32'd2);
        bus.ser_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("abort_valid", 32'(bus.ser_valid), 32'd0);
        chk("abort_sel",   32'(bus.sel),       32'd0);
        chk("abort_q",     32'(exp_q.size()),  32'd0);
        rst = 1'b0;
        bus.ser_ready = 1'b1;
        send_word(4'b1000);
        wait_drain();

        // 6: load_valid during SHIFT ignored
        send_word(4'b1001);
        bus.load_valid = 1'b1;
        bus.din        = 4'b1111;
        step();
        step();
        bus.load_valid = 1'b0;
        wait_drain();
        for (int i = 0; i < 8; i++) step();
        chk("no_extra_frame", 32'(bus.ser_valid), 32'd0);
        chk("final_q",        32'(exp_q.size()),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
